// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
//   byte_valid/byte_data/byte_ready : host byte stream (valid/ready handshake)
//   mem_we/mem_addr/mem_wdata       : single-cycle word write into instruction memory
// slave  = loader side (consumes bytes, drives the memory write port)
// master = host/memory side (drives bytes, observes the write port)
interface imem_loader_if #(
  parameter int unsigned ADDR_BITS = 5
);
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to
// consecutive instruction-memory word addresses starting at 0.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : begin a load (IDLE only); word_count latched here, 0 = full memory
//   abort         : cancel from any state, highest priority
//   bus (slave)   : byte stream in, memory write port out
//   busy          : high whenever not IDLE
//   done          : one-cycle pulse after the final word is written
//   words_loaded  : words written in the current or last load
module imem_loader #(
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   word_count,
  input  logic                 abort,
  imem_loader_if.slave         bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_eff;
  logic [1:0]       byte_idx;
  logic             last_word;
  logic             byte_take;
  logic             ready_nxt;
  logic             we_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // A latched count of 0 means the whole memory.
  assign count_eff = (count_q == '0) ? FULL_COUNT : count_q;
  assign last_word = (words_loaded + CNT_W'(1)) == count_eff;
  assign byte_take = (state == S_COLLECT) && bus.byte_valid && !abort;

  // State register; status outputs are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.byte_ready <= ready_nxt;
      bus.mem_we     <= we_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_COLLECT;
        S_COLLECT: if (bus.byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
        S_WRITE:   state_nxt = last_word ? S_DONE : S_COLLECT;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    ready_nxt = 1'b0;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    ready_nxt = (state_nxt == S_COLLECT);
    we_nxt    = (state_nxt == S_WRITE);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_DONE);
  end

  // Datapath: count latch, byte packing, address and progress counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q       <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      byte_idx      <= '0;
      words_loaded  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            count_q       <= word_count;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            byte_idx      <= '0;
            words_loaded  <= '0;
          end
        end
        S_COLLECT: begin
          if (byte_take) begin
            bus.mem_wdata[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          // The write itself always completes; an abort only withholds credit.
          bus.mem_addr <= bus.mem_addr + ADDR_BITS'(1);
          byte_idx     <= '0;
          if (!abort) words_loaded <= words_loaded + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that writes programs into the word-aligned instruction memory, the write-side counterpart of the combinational instruction fetch port. It accepts bytes over a valid/ready stream (e.g. from a UART receiver or debug host), packs each group of four bytes little-endian into a 32-bit instruction word, and issues one single-cycle write per word at consecutive word addresses starting at 0. It sits between the host byte source and the instruction memory's write port, and holds the core off via `busy` while loading.

## Interface
- `ADDR_BITS`, default 5: word-address width; memory depth is 2^ADDR_BITS words, i.e. 4·2^ADDR_BITS bytes.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `word_count`  in  ADDR_BITS+1  words to load, latched on an accepted `start`; 0 means 2^ADDR_BITS (full memory).
- `abort`  in  1  cancel the load from any state.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  incoming program byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_BITS  word address; byte address = `mem_addr`·4.
- `mem_wdata`  out  32  assembled instruction word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the final word has been written.
- `words_loaded`  out  ADDR_BITS+1  words written in the current or last load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `byte_ready`=0. On `start`=1: latch `word_count`; clear `mem_addr`, the byte index, `words_loaded` and `mem_wdata`; go to COLLECT.
- COLLECT: `byte_ready`=1. A byte transfers when `byte_valid` and `byte_ready` are both high. Byte index k (0..3) is written to `mem_wdata[8k+7:8k]`, so the first byte is the LSB. When the 4th byte transfers, go to WRITE. While `byte_valid` is low, hold state.
- WRITE: `mem_we`=1 and `byte_ready`=0 for exactly one cycle; `mem_addr` and `mem_wdata` are stable. On exit:
  - `mem_addr` increments modulo 2^ADDR_BITS;
  - `words_loaded` increments;
  - the byte index clears.
  - If the new `words_loaded` equals the latched count (0 treated as 2^ADDR_BITS), go to DONE; otherwise go to COLLECT.
- DONE: `done`=1 for one cycle, then go to IDLE. `words_loaded` and the last `mem_addr`/`mem_wdata` are retained until the next accepted `start`.
- `abort`=1: go to IDLE next cycle from any state.
  - Abort has priority over all other transitions.
  - An abort in WRITE still completes that cycle's write, but `words_loaded` does not increment.
  - A partial word is discarded.
  - `done` is not asserted.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins and the loader stays in IDLE.
- Address wrap: `mem_addr` rolls from 2^ADDR_BITS−1 to 0. This is reachable only at the end of a full-memory load, so no overwrite occurs within one load.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces, on that edge:
  - state = IDLE;
  - `byte_ready`, `mem_we`, `busy`, `done` = 0;
  - `mem_addr` = 0, `mem_wdata` = 0, `words_loaded` = 0.
- Reset overrides `abort` and `start`. Reset mid-load discards all progress.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.
- `start` in cycle t puts the loader in COLLECT in cycle t+1, so `busy`=1 and `byte_ready`=1 from t+1.
- Maximum throughput is 5 cycles per word: 4 byte-transfer cycles plus 1 WRITE cycle. If the 4th byte transfers in cycle t, `mem_we`=1 in cycle t+1.
- If the last WRITE is in cycle w, `done`=1 in cycle w+1, and the loader is in IDLE with `busy`=0 in cycle w+2.
- Minimum full load at ADDR_BITS=5: 1 start cycle + 32×5 cycles + 1 DONE cycle.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0 and `byte_ready`=0. After release with no `start`, the block stays idle indefinitely.
- Single word: `start` with `word_count`=1, then bytes 0x93,0x00,0x10,0x00 on consecutive cycles → exactly one `mem_we` at `mem_addr`=0 with `mem_wdata`=0x00100093; `done` pulses the next cycle; `words_loaded`=1.
- Stalled stream: `word_count`=2, with `byte_valid` toggling 1/0 every cycle → writes at addr 0 then 1 with correct words, no extra or duplicate byte captures, `byte_ready` low during WRITE.
- Full memory: `word_count`=0 with ADDR_BITS=5, 128 bytes streamed back-to-back → 32 writes at addr 0..31; `mem_addr` ends at 0; `words_loaded`=32; one `done` pulse.
- Abort: `abort` after 2 bytes of word 1 → no write, IDLE next cycle, `done`=0. A new `start` with count 1 then writes to addr 0 with only the new bytes.
- Misuse: `start` pulsed during COLLECT is ignored and the count is unchanged. `rst_n` low mid-load → all outputs 0 the next cycle and no further `mem_we`.
